// File: rtl/riscv_lsu.sv
// RV32 load/store unit: a single outstanding access with size/alignment
// checking, store byte-lane steering and load extraction with sign/zero extension.
module riscv_lsu #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_is_store,
    input  logic [2:0]              req_funct3,
    input  logic [DATA_WIDTH-1:0]   req_addr,
    input  logic [DATA_WIDTH-1:0]   req_wdata,
    input  logic [4:0]              req_rd,
    output logic                    resp_valid,
    input  logic                    resp_ready,
    output logic [DATA_WIDTH-1:0]   resp_rdata,
    output logic [4:0]              resp_rd,
    output logic                    resp_err,
    output logic                    mem_req,
    input  logic                    mem_gnt,
    output logic                    mem_we,
    output logic [DATA_WIDTH-1:0]   mem_addr,
    output logic [DATA_WIDTH/8-1:0] mem_be,
    output logic [DATA_WIDTH-1:0]   mem_wdata,
    input  logic                    mem_rvalid,
    input  logic [DATA_WIDTH-1:0]   mem_rdata
);

    localparam int BE_W = DATA_WIDTH / 8;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_RESP
    } state_t;

    state_t state_q, state_d;

    logic [DATA_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic [2:0]            funct3_q;
    logic                  store_q;
    logic                  err_q;
    logic [4:0]            rd_q;

    logic                  accept;
    logic                  f3_illegal;
    logic                  misaligned;
    logic                  acc_err;
    logic [BE_W-1:0]       store_be;
    logic [DATA_WIDTH-1:0] store_data;
    logic [DATA_WIDTH-1:0] load_shifted;
    logic [DATA_WIDTH-1:0] load_data;

    // Request screening: funct3[1:0] encodes the access size for both loads and stores.
    always_comb begin
        f3_illegal = 1'b0;
        misaligned = 1'b0;
        if (req_is_store) begin
            f3_illegal = req_funct3[2] | (req_funct3[1:0] == 2'b11);
        end else begin
            f3_illegal = (req_funct3[1:0] == 2'b11) | (req_funct3[2:1] == 2'b11);
        end
        case (req_funct3[1:0])
            2'b01:   misaligned = req_addr[0];
            2'b10:   misaligned = |req_addr[1:0];
            default: misaligned = 1'b0;
        endcase
    end

    assign acc_err = f3_illegal | misaligned;
    assign accept  = (state_q == S_IDLE) & req_valid & ~rst;

    always_comb begin
        store_be   = '1;
        store_data = wdata_q;
        case (funct3_q)
            F3_B: begin
                store_be   = BE_W'(1) << addr_q[1:0];
                store_data = {BE_W{wdata_q[7:0]}};
            end
            F3_H: begin
                store_be   = BE_W'(2'b11) << {addr_q[1], 1'b0};
                store_data = {(BE_W/2){wdata_q[15:0]}};
            end
            F3_W: begin
                store_be   = '1;
                store_data = wdata_q;
            end
            default: begin
                store_be   = '1;
                store_data = wdata_q;
            end
        endcase
    end

    assign load_shifted = mem_rdata >> {addr_q[1:0], 3'b000};

    always_comb begin
        load_data = load_shifted;
        case (funct3_q)
            F3_B:    load_data = {{(DATA_WIDTH-8){load_shifted[7]}}, load_shifted[7:0]};
            F3_H:    load_data = {{(DATA_WIDTH-16){load_shifted[15]}}, load_shifted[15:0]};
            F3_BU:   load_data = {{(DATA_WIDTH-8){1'b0}}, load_shifted[7:0]};
            F3_HU:   load_data = {{(DATA_WIDTH-16){1'b0}}, load_shifted[15:0]};
            default: load_data = load_shifted;
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid) state_d = acc_err ? S_RESP : S_REQ;
            end
            S_REQ: begin
                if (mem_gnt) state_d = store_q ? S_RESP : S_WAIT;
            end
            S_WAIT: begin
                if (mem_rvalid) state_d = S_RESP;
            end
            S_RESP: begin
                if (resp_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Read data is cleared on accept so stores and rejected requests report zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            funct3_q <= '0;
            store_q  <= 1'b0;
            err_q    <= 1'b0;
            rd_q     <= '0;
        end else if (accept) begin
            addr_q   <= req_addr;
            wdata_q  <= req_wdata;
            rdata_q  <= '0;
            funct3_q <= req_funct3;
            store_q  <= req_is_store;
            err_q    <= acc_err;
            rd_q     <= req_rd;
        end else if ((state_q == S_WAIT) && mem_rvalid) begin
            rdata_q  <= load_data;
        end
    end

    // Outputs are Moore-decoded and forced low while reset is asserted.
    always_comb begin
        req_ready  = 1'b0;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_be     = '0;
        mem_wdata  = '0;
        resp_valid = 1'b0;
        resp_rdata = '0;
        resp_rd    = '0;
        resp_err   = 1'b0;
        if (!rst) begin
            case (state_q)
                S_IDLE: begin
                    req_ready = 1'b1;
                end
                S_REQ: begin
                    mem_req   = 1'b1;
                    mem_we    = store_q;
                    mem_addr  = {addr_q[DATA_WIDTH-1:2], 2'b00};
                    mem_be    = store_q ? store_be : '1;
                    mem_wdata = store_q ? store_data : '0;
                end
                S_RESP: begin
                    resp_valid = 1'b1;
                    resp_rdata = rdata_q;
                    resp_rd    = rd_q;
                    resp_err   = err_q;
                end
                default: begin
                    req_ready = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_riscv_lsu.sv
// Self-checking bench for riscv_lsu: directed vector table, reset corner
// sequences and randomized transactions against a byte-level reference model.
module tb_riscv_lsu;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_is_store;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [4:0]  req_rd;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic [4:0]  resp_rd;
    logic        resp_err;
    logic        mem_req;
    logic        mem_gnt;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    typedef struct {
        logic        is_store;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic [4:0]  rd;
        int unsigned gd;
        int unsigned rvd;
        int unsigned ryd;
        logic        e_err;
        logic [31:0] e_rdata;
        logic [31:0] e_maddr;
        logic [31:0] e_wdata;
        logic [3:0]  e_be;
        int unsigned e_lat;
    } vec_t;

    vec_t       vecs [16];
    logic [2:0] ld_ok [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};

    riscv_lsu #(.DATA_WIDTH(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_is_store (req_is_store),
        .req_funct3   (req_funct3),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .req_rd       (req_rd),
        .resp_valid   (resp_valid),
        .resp_ready   (resp_ready),
        .resp_rdata   (resp_rdata),
        .resp_rd      (resp_rd),
        .resp_err     (resp_err),
        .mem_req      (mem_req),
        .mem_gnt      (mem_gnt),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_be       (mem_be),
        .mem_wdata    (mem_wdata),
        .mem_rvalid   (mem_rvalid),
        .mem_rdata    (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endfunction

    // Reference: treat the bus word as four bytes, pick size bytes starting at
    // the byte offset, and extend arithmetically; stores fill each lane from
    // the source byte at (lane mod size).
    function automatic vec_t model(input vec_t v);
        vec_t        r;
        int unsigned size;
        int unsigned a;
        bit          sgn;
        longint      val;
        r    = v;
        size = 0;
        sgn  = 1'b0;
        a    = 32'(v.addr[1:0]);
        case (v.f3)
            3'd0:    begin size = 1; sgn = 1'b1; end
            3'd1:    begin size = 2; sgn = 1'b1; end
            3'd2:    size = 4;
            3'd4:    size = 1;
            3'd5:    size = 2;
            default: size = 0;
        endcase
        if (v.is_store && (v.f3 > 3'd2)) size = 0;
        r.e_rdata = 32'h0;
        r.e_maddr = v.addr & 32'hFFFF_FFFC;
        r.e_wdata = 32'h0;
        r.e_be    = 4'h0;
        r.e_err   = 1'b1;
        r.e_lat   = 1;
        if (size != 0) begin
            if ((a % size) == 0) begin
                r.e_err = 1'b0;
                if (v.is_store) begin
                    for (int i = 0; i < int'(size); i++) r.e_be[int'(a) + i] = 1'b1;
                    for (int j = 0; j < 4; j++) r.e_wdata[8*j +: 8] = v.wdata[8*(j % int'(size)) +: 8];
                    r.e_lat = 2 + v.gd;
                end else begin
                    r.e_be = 4'hF;
                    val    = 0;
                    for (int i = 0; i < int'(size); i++)
                        val += longint'(v.rdata[8*(int'(a) + i) +: 8]) << (8*i);
                    if (sgn && (val >= (longint'(1) << (8*size - 1))))
                        val -= (longint'(1) << (8*size));
                    r.e_rdata = val[31:0];
                    r.e_lat   = 3 + v.gd + v.rvd;
                end
            end
        end
        return r;
    endfunction

    // Starts in an IDLE cycle just after a rising edge; ends likewise.
    task automatic run_vec(input vec_t v, input string tag);
        int unsigned cyc, req_cycles, resp_cycles, resp_at, gnt_at;
        int unsigned viol_mem, viol_resp, viol_rdy;
        bit          got_cmd, got_resp, done, granted;
        logic        c_we;
        logic [31:0] c_addr, c_wdata;
        logic [3:0]  c_be;
        logic [31:0] r_data;
        logic [4:0]  r_rd;
        logic        r_err;
        req_cycles = 0; resp_cycles = 0; resp_at = 0; gnt_at = 0;
        viol_mem = 0; viol_resp = 0; viol_rdy = 0;
        got_cmd = 0; got_resp = 0; done = 0; granted = 0;
        c_we = 1'b0; c_addr = '0; c_wdata = '0; c_be = '0;
        r_data = '0; r_rd = '0; r_err = 1'b0;

        req_valid    = 1'b1;
        req_is_store = v.is_store;
        req_funct3   = v.f3;
        req_addr     = v.addr;
        req_wdata    = v.wdata;
        req_rd       = v.rd;
        @(negedge clk);
        check($sformatf("%s.accept_ready", tag), 32'(req_ready), 32'd1);
        @(posedge clk); #1;
        req_valid    = 1'b0;
        req_is_store = 1'($urandom_range(0, 1));
        req_funct3   = 3'($urandom_range(0, 7));
        req_addr     = $urandom;
        req_wdata    = $urandom;
        req_rd       = 5'($urandom_range(0, 31));
        cyc = 1;
        while (!done && (cyc < 40)) begin
            mem_gnt    = 1'b0;
            mem_rvalid = 1'b0;
            resp_ready = 1'b0;
            mem_rdata  = $urandom;
            if (req_ready) viol_rdy++;
            if (mem_req) begin
                if (!got_cmd) begin
                    got_cmd = 1; c_we = mem_we; c_addr = mem_addr; c_be = mem_be; c_wdata = mem_wdata;
                end else if ((mem_we !== c_we) || (mem_addr !== c_addr) || (mem_be !== c_be) || (mem_wdata !== c_wdata)) begin
                    viol_mem++;
                end
                if (req_cycles == v.gd) begin
                    mem_gnt = 1'b1; gnt_at = cyc; granted = 1;
                end else begin
                    mem_rvalid = 1'b1;
                end
                req_cycles++;
            end
            if (granted && !v.is_store && (cyc == gnt_at + 1 + v.rvd)) begin
                mem_rvalid = 1'b1;
                mem_rdata  = v.rdata;
            end
            if (resp_valid) begin
                if (!got_resp) begin
                    got_resp = 1; resp_at = cyc; r_data = resp_rdata; r_rd = resp_rd; r_err = resp_err;
                end else if ((resp_rdata !== r_data) || (resp_rd !== r_rd) || (resp_err !== r_err)) begin
                    viol_resp++;
                end
                if (resp_cycles == v.ryd) begin
                    resp_ready = 1'b1; done = 1;
                end else if (!mem_rvalid) begin
                    mem_rvalid = 1'b1;
                end
                resp_cycles++;
            end
            @(posedge clk); #1;
            cyc++;
        end
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b0;
        resp_ready = 1'b0;

        check($sformatf("%s.completed", tag), 32'(done), 32'd1);
        check($sformatf("%s.idle_ready", tag), 32'(req_ready), 32'd1);
        check($sformatf("%s.idle_resp_valid", tag), 32'(resp_valid), 32'd0);
        check($sformatf("%s.latency", tag), resp_at, v.e_lat);
        check($sformatf("%s.err", tag), 32'(r_err), 32'(v.e_err));
        check($sformatf("%s.rdata", tag), r_data, v.e_rdata);
        check($sformatf("%s.rd", tag), 32'(r_rd), 32'(v.rd));
        check($sformatf("%s.resp_stable", tag), viol_resp, 32'd0);
        check($sformatf("%s.ready_low", tag), viol_rdy, 32'd0);
        if (v.e_err) begin
            check($sformatf("%s.mem_cycles", tag), req_cycles, 32'd0);
        end else begin
            check($sformatf("%s.mem_we", tag), 32'(c_we), 32'(v.is_store));
            check($sformatf("%s.mem_addr", tag), c_addr, v.e_maddr);
            check($sformatf("%s.mem_be", tag), 32'(c_be), 32'(v.e_be));
            check($sformatf("%s.mem_cycles", tag), req_cycles, v.gd + 1);
            check($sformatf("%s.mem_stable", tag), viol_mem, 32'd0);
            if (v.is_store) check($sformatf("%s.mem_wdata", tag), c_wdata, v.e_wdata);
        end
    endtask

    initial begin
        //          st    f3    addr          wdata         rdata         rd    gd rvd ryd err   e_rdata       e_maddr       e_wdata       be    lat
        vecs[0]  = '{1'b0, 3'd0, 32'h0000_0103, 32'h0000_0000, 32'h80FF_1234, 5'd1,  0, 0, 0, 1'b0, 32'hFFFF_FF80, 32'h0000_0100, 32'h0000_0000, 4'hF, 3};
        vecs[1]  = '{1'b0, 3'd5, 32'h0000_0202, 32'h0000_0000, 32'hBEEF_0000, 5'd2,  0, 0, 0, 1'b0, 32'h0000_BEEF, 32'h0000_0200, 32'h0000_0000, 4'hF, 3};
        vecs[2]  = '{1'b0, 3'd1, 32'h0000_0202, 32'h0000_0000, 32'hBEEF_0000, 5'd3,  0, 0, 0, 1'b0, 32'hFFFF_BEEF, 32'h0000_0200, 32'h0000_0000, 4'hF, 3};
        vecs[3]  = '{1'b1, 3'd0, 32'h0000_0011, 32'h0000_00AB, 32'h0000_0000, 5'd4,  0, 0, 0, 1'b0, 32'h0000_0000, 32'h0000_0010, 32'hABAB_ABAB, 4'h2, 2};
        vecs[4]  = '{1'b0, 3'd2, 32'h0000_0102, 32'h0000_0000, 32'h1111_2222, 5'd5,  0, 0, 0, 1'b1, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 4'h0, 1};
        vecs[5]  = '{1'b1, 3'd1, 32'h0000_0101, 32'h5555_AAAA, 32'h0000_0000, 5'd6,  0, 0, 0, 1'b1, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 4'h0, 1};
        vecs[6]  = '{1'b0, 3'd3, 32'h0000_0100, 32'h0000_0000, 32'h0000_0000, 5'd7,  0, 0, 0, 1'b1, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 4'h0, 1};
        vecs[7]  = '{1'b1, 3'd2, 32'h0000_0020, 32'h1234_5678, 32'h0000_0000, 5'd8,  3, 0, 2, 1'b0, 32'h0000_0000, 32'h0000_0020, 32'h1234_5678, 4'hF, 5};
        vecs[8]  = '{1'b0, 3'd2, 32'h0000_0040, 32'h0000_0000, 32'hDEAD_BEEF, 5'd9,  3, 2, 2, 1'b0, 32'hDEAD_BEEF, 32'h0000_0040, 32'h0000_0000, 4'hF, 8};
        vecs[9]  = '{1'b0, 3'd4, 32'h0000_0301, 32'h0000_0000, 32'h0000_8000, 5'd10, 0, 0, 0, 1'b0, 32'h0000_0080, 32'h0000_0300, 32'h0000_0000, 4'hF, 3};
        vecs[10] = '{1'b1, 3'd1, 32'h0000_0002, 32'hFFFF_1234, 32'h0000_0000, 5'd11, 0, 0, 0, 1'b0, 32'h0000_0000, 32'h0000_0000, 32'h1234_1234, 4'hC, 2};
        vecs[11] = '{1'b1, 3'd4, 32'h0000_0008, 32'h0000_0001, 32'h0000_0000, 5'd12, 0, 0, 0, 1'b1, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 4'h0, 1};
        vecs[12] = '{1'b0, 3'd5, 32'h0000_0000, 32'h0000_0000, 32'h1234_F00D, 5'd13, 0, 1, 0, 1'b0, 32'h0000_F00D, 32'h0000_0000, 32'h0000_0000, 4'hF, 4};
        vecs[13] = '{1'b0, 3'd7, 32'h0000_0004, 32'h0000_0000, 32'h0000_0000, 5'd14, 0, 0, 1, 1'b1, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 4'h0, 1};
        vecs[14] = '{1'b0, 3'd0, 32'h0000_0007, 32'h0000_0000, 32'h7F00_0000, 5'd15, 0, 0, 0, 1'b0, 32'h0000_007F, 32'h0000_0004, 32'h0000_0000, 4'hF, 3};
        vecs[15] = '{1'b0, 3'd1, 32'h0000_0003, 32'h0000_0000, 32'h0000_0000, 5'd16, 0, 0, 0, 1'b1, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 4'h0, 1};

        rst = 1'b1;
        req_valid = 1'b1;
        req_is_store = 1'b0; req_funct3 = 3'd2; req_addr = 32'h100; req_wdata = '0; req_rd = 5'd1;
        resp_ready = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset.req_ready", 32'(req_ready), 32'd0);
        check("reset.mem_req", 32'(mem_req), 32'd0);
        check("reset.resp_valid", 32'(resp_valid), 32'd0);
        check("reset.mem_outputs", {mem_addr[27:0], mem_be} | mem_wdata | 32'(mem_we), 32'd0);
        check("reset.resp_outputs", resp_rdata | 32'(resp_rd) | 32'(resp_err), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        req_valid = 1'b0;
        @(negedge clk);
        check("reset.ready_after", 32'(req_ready), 32'd1);
        @(posedge clk); #1;

        for (int i = 0; i < 16; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

        // Reset while waiting for read data, followed by a stray rvalid.
        req_valid = 1'b1; req_is_store = 1'b0; req_funct3 = 3'd2; req_addr = 32'h80; req_rd = 5'd7;
        @(posedge clk); #1;
        req_valid = 1'b0;
        check("rst_wait.mem_req", 32'(mem_req), 32'd1);
        mem_gnt = 1'b1;
        @(posedge clk); #1;
        mem_gnt = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        check("rst_wait.outputs_low", 32'({req_ready, mem_req, resp_valid}), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        mem_rvalid = 1'b1; mem_rdata = 32'hCAFE_F00D;
        @(negedge clk);
        check("rst_wait.ready_after", 32'(req_ready), 32'd1);
        @(posedge clk); #1;
        mem_rvalid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check($sformatf("rst_wait.no_resp%0d", k), 32'({resp_valid, req_ready}), 32'd1);
        end
        @(posedge clk); #1;
        run_vec(vecs[0], "post_rst_wait");

        // Reset while a store is still waiting for grant.
        req_valid = 1'b1; req_is_store = 1'b1; req_funct3 = 3'd2; req_addr = 32'h44; req_wdata = 32'h0BAD_0BAD; req_rd = 5'd3;
        @(posedge clk); #1;
        req_valid = 1'b0;
        check("rst_req.mem_req", 32'(mem_req), 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        mem_gnt = 1'b1;
        @(negedge clk);
        check("rst_req.mem_req_dropped", 32'(mem_req), 32'd0);
        check("rst_req.ready_after", 32'(req_ready), 32'd1);
        @(posedge clk); #1;
        mem_gnt = 1'b0;
        @(negedge clk);
        check("rst_req.no_resp", 32'(resp_valid), 32'd0);
        @(posedge clk); #1;
        run_vec(vecs[3], "post_rst_req");

        for (int k = 0; k < 150; k++) begin
            vec_t v;
            v.is_store = 1'($urandom_range(0, 1));
            v.f3       = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 3) != 0)
                v.f3 = v.is_store ? 3'($urandom_range(0, 2)) : ld_ok[$urandom_range(0, 4)];
            v.addr  = $urandom;
            if ($urandom_range(0, 1) != 0) v.addr[1:0] = 2'b00;
            v.wdata = $urandom;
            v.rdata = $urandom;
            v.rd    = 5'($urandom_range(0, 31));
            v.gd    = $urandom_range(0, 3);
            v.rvd   = $urandom_range(0, 3);
            v.ryd   = $urandom_range(0, 2);
            run_vec(model(v), $sformatf("rand%0d", k));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
